// File: rtl/common_pkg.sv
// Shared types and constants for the fetch stage and its neighbours.
package common_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] word_t;
    typedef logic [XLEN-1:0] instr_t;

    localparam word_t BOOT_ADDR_DEFAULT  = 32'h0000_1000;
    localparam word_t EXC_VECTOR_DEFAULT = 32'h0000_2000;
    localparam word_t PC_STEP            = 32'd4;

    // FETCH: normal requests; MISS: waiting on a fill; KILL: draining a fill after a redirect
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        MISS  = 2'd1,
        KILL  = 2'd2
    } fetch_state_t;

    // Fetch/decode pipeline register payload
    typedef struct packed {
        instr_t instr;
        word_t  pc;
        logic   valid;
    } fd_reg_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the i-cache request port and
// registers fetched words into the F/D register.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   icache_req/icache_addr           fetch request and address (address from registers only)
//   icache_ready/icache_data         response valid and instruction word
//   stall                            hold F/D and PC
//   redirect/redirect_pc             taken branch/jump target
//   exception                        jump to EXC_VECTOR
//   iret/iret_pc                     return from exception
//   instr/instr_pc/instr_valid       F/D register outputs to decode
module fetch_stage
    import common_pkg::*;
#(
    parameter word_t BOOT_ADDR  = BOOT_ADDR_DEFAULT,
    parameter word_t EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic   clk,
    input  logic   rst_n,
    output logic   icache_req,
    output word_t  icache_addr,
    input  logic   icache_ready,
    input  instr_t icache_data,
    input  logic   stall,
    input  logic   redirect,
    input  word_t  redirect_pc,
    input  logic   exception,
    input  logic   iret,
    input  word_t  iret_pc,
    output instr_t instr,
    output word_t  instr_pc,
    output logic   instr_valid
);

    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        tgt_q, tgt_d;
    fd_reg_t      fd_q, fd_d;
    logic         req_q;
    logic         redir;
    word_t        redir_pc;

    // Next-PC priority mux for redirect sources
    always_comb begin
        redir = exception | iret | redirect;
        if (exception) begin
            redir_pc = EXC_VECTOR;
        end else if (iret) begin
            redir_pc = iret_pc;
        end else begin
            redir_pc = redirect_pc;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= BOOT_ADDR;
            tgt_q   <= '0;
            fd_q    <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            fd_q    <= fd_d;
            req_q   <= 1'b1;
        end
    end

    // Next-state and next-datapath logic; a redirect always flushes before capture
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        fd_d    = fd_q;
        case (state_q)
            FETCH: begin
                if (redir) begin
                    pc_d       = redir_pc;
                    fd_d.valid = 1'b0;
                end else if (req_q && icache_ready) begin
                    // a stalled hit is dropped and re-requested at the same PC
                    if (!stall) begin
                        fd_d = '{instr: icache_data, pc: pc_q, valid: 1'b1};
                        pc_d = pc_q + PC_STEP;
                    end
                end else if (req_q) begin
                    state_d = MISS;
                    if (!stall) begin
                        fd_d.valid = 1'b0;
                    end
                end
            end
            MISS: begin
                if (redir) begin
                    fd_d.valid = 1'b0;
                    if (icache_ready) begin
                        state_d = FETCH;
                        pc_d    = redir_pc;
                    end else begin
                        // fill cannot be aborted: keep address, park the target
                        state_d = KILL;
                        tgt_d   = redir_pc;
                    end
                end else if (icache_ready) begin
                    state_d = FETCH;
                    if (!stall) begin
                        fd_d = '{instr: icache_data, pc: pc_q, valid: 1'b1};
                        pc_d = pc_q + PC_STEP;
                    end
                end else if (!stall) begin
                    fd_d.valid = 1'b0;
                end
            end
            KILL: begin
                fd_d.valid = 1'b0;
                if (redir) begin
                    tgt_d = redir_pc;
                end
                if (icache_ready) begin
                    state_d = FETCH;
                    pc_d    = redir ? redir_pc : tgt_q;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Outputs: all driven from registers
    always_comb begin
        icache_req  = req_q;
        icache_addr = pc_q;
        instr       = fd_q.instr;
        instr_pc    = fd_q.pc;
        instr_valid = fd_q.valid;
    end

endmodule
